// File: rtl/pqc_reduce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pqc_reduce_pkg
// Description : Shared types and latency constants for the polynomial
//               reduction sequencer and its address generators.
// Revision    : 1.0 - initial release
// ============================================================================
package pqc_reduce_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } red_state_t;

    localparam int RED_LAT   = 1;  // Barrett unit result latency
    localparam int RD_LAT    = 1;  // coefficient RAM read latency
    localparam int FLUSH_CYC = 2;  // flush cycles held after the abort cycle

endpackage
`default_nettype wire

// File: rtl/reduce_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : reduce_addr_gen
// Description : Base register plus word counter; emits base + count modulo
//               2^ADDR_W. Used once for the read side and once for writeback.
// Revision    : 1.0 - initial release
// ============================================================================
module reduce_addr_gen #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [CNT_W-1:0]  cnt_o
);

    logic [ADDR_W-1:0] r_base;
    logic [CNT_W-1:0]  r_cnt;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_base <= '0;
            r_cnt  <= '0;
        end else if (load_i) begin
            r_base <= base_i;
            r_cnt  <= '0;
        end else if (inc_i) begin
            r_cnt  <= r_cnt + CNT_W'(1);
        end
    end

    // Wraps silently past the top of the address space.
    assign addr_o = r_base + ADDR_W'(r_cnt);
    assign cnt_o  = r_cnt;

endmodule
`default_nettype wire

// File: rtl/poly_reduce_seq.sv
`default_nettype none
// ============================================================================
// Module      : poly_reduce_seq
// Description : Streams one packed polynomial from coefficient RAM through the
//               two-lane Barrett unit and writes the reduced words back.
// Revision    : 1.0 - initial release
// ============================================================================
module poly_reduce_seq
    import pqc_reduce_pkg::*;
#(
    parameter int N_WORDS = 128,
    parameter int ADDR_W  = 8
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] src_base_i,
    input  logic [ADDR_W-1:0] dst_base_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              mem_rd_en_o,
    output logic [ADDR_W-1:0] mem_rd_addr_o,
    input  logic [31:0]       mem_rd_data_i,
    output logic              red_valid_o,
    output logic [31:0]       red_src_o,
    output logic              red_flush_o,
    input  logic              red_valid_i,
    input  logic [31:0]       red_result_i,
    output logic              mem_wr_en_o,
    output logic [ADDR_W-1:0] mem_wr_addr_o,
    output logic [31:0]       mem_wr_data_o
);

    localparam int               c_cnt_w = $clog2(N_WORDS) + 1;
    localparam int               c_fl_w  = $clog2(FLUSH_CYC + 1);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(N_WORDS - 1);
    localparam logic [c_fl_w-1:0]  c_flush = c_fl_w'(FLUSH_CYC);

    red_state_t          r_state;
    red_state_t          w_state_nxt;
    logic                r_rd_en_q;
    logic [c_fl_w-1:0]   r_flush_cnt;
    logic                w_busy;
    logic                w_abort;
    logic                w_flush;
    logic                w_rd_en;
    logic                w_wr_en;
    logic                w_load;
    logic [c_cnt_w-1:0]  w_rd_cnt;
    logic [c_cnt_w-1:0]  w_wr_cnt;

    assign w_busy  = (r_state == RUN) || (r_state == DRAIN);
    assign w_abort = abort_i & w_busy;
    // Flush covers the abort cycle itself plus the FLUSH_CYC cycles after it.
    assign w_flush = w_abort | (r_flush_cnt != '0);
    assign w_wr_en = red_valid_i & w_busy & ~w_flush;

    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_state_nxt = RUN;
                    w_load      = 1'b1;
                end
            end
            RUN: begin
                if (abort_i) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_rd_en = 1'b1;
                    if (w_rd_cnt == c_last) begin
                        w_state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (abort_i) begin
                    w_state_nxt = IDLE;
                end else if (w_wr_en && (w_wr_cnt == c_last)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_state     <= IDLE;
            r_rd_en_q   <= 1'b0;
            r_flush_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_rd_en_q <= w_rd_en;
            if (w_abort) begin
                r_flush_cnt <= c_flush;
            end else if (r_flush_cnt != '0) begin
                r_flush_cnt <= r_flush_cnt - c_fl_w'(1);
            end
        end
    end

    reduce_addr_gen #(
        .ADDR_W (ADDR_W),
        .CNT_W  (c_cnt_w)
    ) u_rd_addr (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .load_i (w_load),
        .base_i (src_base_i),
        .inc_i  (w_rd_en),
        .addr_o (mem_rd_addr_o),
        .cnt_o  (w_rd_cnt)
    );

    reduce_addr_gen #(
        .ADDR_W (ADDR_W),
        .CNT_W  (c_cnt_w)
    ) u_wr_addr (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .load_i (w_load),
        .base_i (dst_base_i),
        .inc_i  (w_wr_en),
        .addr_o (mem_wr_addr_o),
        .cnt_o  (w_wr_cnt)
    );

    assign busy_o        = w_busy;
    assign done_o        = (r_state == DONE);
    assign mem_rd_en_o   = w_rd_en;
    assign red_valid_o   = r_rd_en_q & ~w_flush;
    assign red_src_o     = mem_rd_data_i;
    assign red_flush_o   = w_flush;
    assign mem_wr_en_o   = w_wr_en;
    assign mem_wr_data_o = red_result_i;

endmodule
`default_nettype wire

// File: tb/tb_poly_reduce_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_poly_reduce_seq
// Description : Self-checking bench: two sequencer instances (128 and 16
//               words) with RAM and Barrett models, table-driven passes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_poly_reduce_seq;

    typedef struct {
        int d;         // 0: 128-word instance, 1: 16-word instance
        int src;
        int dst;
        int pat;       // 0 const 0x0D010001, 1 {k+3329,k}, 2 random
        int ab0;       // abort_i asserted together with start
        int abort_at;  // cycle of abort pulse, 0 = none
        int rst_at;    // cycle of reset pulse, 0 = none
        int st_a;      // extra start pulses, 0 = none
        int st_b;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        abort;
    logic [1:0]  start;
    logic [1:0]  ld;
    logic [7:0]  src_base;
    logic [7:0]  dst_base;
    logic [1:0]  busy, done, rd_en, red_valid, flush, wr_en;
    logic [7:0]  rd_addr [2];
    logic [7:0]  wr_addr [2];
    logic [31:0] red_src [2];
    logic [31:0] wr_data [2];
    logic [31:0] img [256];
    vec_t        tab [12];
    int          total = 0;
    int          bad   = 0;

    function automatic logic [31:0] red_w(input logic [31:0] w);
        return {16'(w[31:16] % 16'd3329), 16'(w[15:0] % 16'd3329)};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_h
        localparam int NW = (g == 0) ? 128 : 16;
        logic [31:0] mem [256];
        logic [31:0] rdata;
        logic        rv_q;
        logic [31:0] res_q;

        poly_reduce_seq #(.N_WORDS(NW), .ADDR_W(8)) u_dut (
            .clk_i         (clk),
            .rstn_i        (rstn),
            .start_i       (start[g]),
            .abort_i       (abort),
            .src_base_i    (src_base),
            .dst_base_i    (dst_base),
            .busy_o        (busy[g]),
            .done_o        (done[g]),
            .mem_rd_en_o   (rd_en[g]),
            .mem_rd_addr_o (rd_addr[g]),
            .mem_rd_data_i (rdata),
            .red_valid_o   (red_valid[g]),
            .red_src_o     (red_src[g]),
            .red_flush_o   (flush[g]),
            .red_valid_i   (rv_q),
            .red_result_i  (res_q),
            .mem_wr_en_o   (wr_en[g]),
            .mem_wr_addr_o (wr_addr[g]),
            .mem_wr_data_o (wr_data[g])
        );

        // RAM with 1-cycle read (old data on same-address write) and a
        // 1-cycle Barrett unit that drops its pipeline on flush.
        always @(posedge clk) begin
            if (ld[g]) begin
                for (int a = 0; a < 256; a++) mem[a] <= img[a];
            end else if (wr_en[g]) begin
                mem[wr_addr[g]] <= wr_data[g];
            end
            if (rd_en[g]) rdata <= mem[rd_addr[g]];
            rv_q  <= red_valid[g] & ~flush[g];
            res_q <= red_w(red_src[g]);
        end
    end

    function automatic logic [31:0] ram_rd(input int d, input int a);
        logic [7:0] ai;
        ai = a[7:0];
        if (d == 0) return g_h[0].mem[ai];
        return g_h[1].mem[ai];
    endfunction

    function automatic int outs_zero(input int d);
        return int'(busy[d] == 1'b0 && done[d] == 1'b0 && rd_en[d] == 1'b0 &&
                    red_valid[d] == 1'b0 && flush[d] == 1'b0 && wr_en[d] == 1'b0 &&
                    rd_addr[d] == 8'd0 && wr_addr[d] == 8'd0);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_row(input int r);
        vec_t        v;
        int          n, tl, nwr, normal;
        logic [31:0] m  [256];
        logic [31:0] rv [128];
        int rd_n, wr_n, v_n, fl_n, dn_n, rd_f, rd_l, v_f, v_l, wr_f, wr_l, fl_f;
        int dn_c, dn_busy, ab_busy, rs_zero, aerr, serr, merr;
        string p;

        v      = tab[r];
        n      = (v.d == 0) ? 128 : 16;
        normal = int'(v.abort_at == 0 && v.rst_at == 0);
        p      = $sformatf("row%0d", r);

        for (int a = 0; a < 256; a++) begin
            case (v.pat)
                0:       img[a] = 32'h0D01_0001;
                1:       img[a] = (a < 128) ? {16'(a + 3329), 16'(a)} : $urandom;
                default: img[a] = $urandom;
            endcase
        end

        // Reference: read k happens in cycle k+1, write k in cycle k+3;
        // within one cycle the read sees memory before that cycle's write.
        for (int a = 0; a < 256; a++) m[a] = img[a];
        tl = (v.abort_at != 0) ? v.abort_at - 1 : (v.rst_at != 0) ? v.rst_at : n + 2;
        for (int t = 1; t <= tl; t++) begin
            if (t - 1 < n) rv[t-1] = m[(v.src + t - 1) % 256];
            if (t >= 3 && t - 3 < n) m[(v.dst + t - 3) % 256] = red_w(rv[t-3]);
        end
        nwr = (tl - 2 < 0) ? 0 : (tl - 2 > n) ? n : tl - 2;

        @(negedge clk); ld[v.d] = 1'b1;
        @(negedge clk); ld = 2'b00;
        src_base = 8'(v.src);
        dst_base = 8'(v.dst);
        start[v.d] = 1'b1;
        abort = (v.ab0 != 0);
        @(posedge clk);

        rd_n = 0; wr_n = 0; v_n = 0; fl_n = 0; dn_n = 0; aerr = 0; serr = 0;
        rd_f = -1; rd_l = -1; v_f = -1; v_l = -1; wr_f = -1; wr_l = -1; fl_f = -1;
        dn_c = -1; dn_busy = -1; ab_busy = -1; rs_zero = -1;
        for (int c = 1; c <= n + 8; c++) begin
            @(negedge clk);
            start[v.d] = (c == v.st_a) || (c == v.st_b);
            abort      = (c == v.abort_at);
            rstn       = (c != v.rst_at);
            #1;
            if (rd_en[v.d]) begin
                if (int'(rd_addr[v.d]) != (v.src + rd_n) % 256) aerr++;
                if (rd_f < 0) rd_f = c;
                rd_l = c; rd_n++;
            end
            if (red_valid[v.d]) begin
                if (v_n >= n || red_src[v.d] !== rv[v_n]) serr++;
                if (v_f < 0) v_f = c;
                v_l = c; v_n++;
            end
            if (wr_en[v.d]) begin
                if (int'(wr_addr[v.d]) != (v.dst + wr_n) % 256) aerr++;
                if (wr_f < 0) wr_f = c;
                wr_l = c; wr_n++;
            end
            if (flush[v.d]) begin
                if (fl_f < 0) fl_f = c;
                fl_n++;
            end
            if (done[v.d]) begin
                dn_n++; dn_c = c; dn_busy = int'(busy[v.d]);
            end
            if (v.abort_at != 0 && c == v.abort_at + 1) ab_busy = int'(busy[v.d]);
            if (v.rst_at != 0 && c == v.rst_at + 1) rs_zero = outs_zero(v.d);
        end
        start = 2'b00; abort = 1'b0; rstn = 1'b1;

        merr = 0;
        for (int a = 0; a < 256; a++) if (ram_rd(v.d, a) !== m[a]) merr++;

        chk({p, " done_count"}, dn_n, normal);
        chk({p, " write_count"}, wr_n, nwr);
        chk({p, " addr_seq_errors"}, aerr, 0);
        chk({p, " operand_errors"}, serr, 0);
        chk({p, " ram_word_errors"}, merr, 0);
        if (normal != 0) begin
            chk({p, " done_cycle"}, dn_c, n + 3);
            chk({p, " busy_at_done"}, dn_busy, 0);
            chk({p, " first_read"}, rd_f, 1);
            chk({p, " last_read"}, rd_l, n);
            chk({p, " first_valid"}, v_f, 2);
            chk({p, " last_valid"}, v_l, n + 1);
            chk({p, " first_write"}, wr_f, 3);
            chk({p, " last_write"}, wr_l, n + 2);
            chk({p, " flush_cycles"}, fl_n, 0);
        end
        if (v.abort_at != 0) begin
            chk({p, " flush_first"}, fl_f, v.abort_at);
            chk({p, " flush_cycles"}, fl_n, 3);
            chk({p, " busy_after_abort"}, ab_busy, 0);
            chk({p, " last_read"}, rd_l, v.abort_at - 1);
            chk({p, " last_write"}, wr_l, v.abort_at - 1);
        end
        if (v.rst_at != 0) begin
            chk({p, " outputs_zero_after_reset"}, rs_zero, 1);
        end
    endtask

    initial begin
        rstn = 1'b0; abort = 1'b0; start = 2'b00; ld = 2'b00;
        src_base = 8'h00; dst_base = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs_dut128", outs_zero(0), 1);
        chk("reset_outputs_dut16", outs_zero(1), 1);
        rstn = 1'b1;

        tab[0] = '{0, 8'h00, 8'h00, 0, 0, 0,  0,  0,   0};
        tab[1] = '{0, 8'h00, 8'h80, 1, 0, 0,  0,  0,   0};
        tab[2] = '{1, 8'hF0, 8'hF8, 2, 0, 0,  0,  0,   0};
        tab[3] = '{0, 8'h00, 8'h80, 2, 0, 50, 0,  0,   0};
        tab[4] = '{0, 8'h10, 8'h10, 2, 0, 0,  0,  0,   0};
        tab[5] = '{0, 8'h00, 8'h00, 0, 0, 0,  0,  10, 131};
        tab[6] = '{0, 8'h00, 8'h00, 2, 0, 0,  40, 0,   0};
        tab[7] = '{0, 8'h00, 8'h00, 0, 0, 0,  0,  0,   0};
        for (int i = 8; i < 12; i++) begin
            tab[i] = '{int'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                       int'($urandom_range(0, 255)), 2, (i == 8) ? 1 : 0, 0, 0, 0, 0};
        end

        for (int r = 0; r < 12; r++) run_row(r);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/poly_reduce_seq.md
# poly_reduce_seq

Sequencer that reduces one packed polynomial held in coefficient RAM through the existing two-lane Barrett unit. On `start_i` it reads `N_WORDS` 32-bit words (two 16-bit coefficients each) from `src_base_i` and streams them into the unit's valid/source port. It collects the unit's valid/result port and writes the reduced words to `dst_base_i`, then pulses `done_o`. It sits between the NTT coefficient memory and the Barrett unit, acting as the unit's producer and consumer.

## Interface
- `N_WORDS`, default 128: words per polynomial (256 coefficients).
- `ADDR_W`, default 8: RAM word-address width.
- `clk_i`  in  1  clock, rising edge.
- `rstn_i`  in  1  reset; synchronous, active-low.
- `start_i`  in  1  start request; sampled only in IDLE.
- `abort_i`  in  1  abandon the current pass.
- `src_base_i`  in  ADDR_W  read base; latched at start.
- `dst_base_i`  in  ADDR_W  write base; latched at start; may equal `src_base_i` (in-place).
- `busy_o`  out  1  high in RUN/DRAIN.
- `done_o`  out  1  one-cycle pulse on normal completion.
- `mem_rd_en_o`  out  1  RAM read strobe.
- `mem_rd_addr_o`  out  ADDR_W  read address.
- `mem_rd_data_i`  in  32  read data, valid exactly 1 cycle after the strobe.
- `red_valid_o`  out  1  operand valid to the Barrett unit.
- `red_src_o`  out  32  operand word, {coefB, coefA}.
- `red_flush_o`  out  1  flush to the Barrett unit.
- `red_valid_i`  in  1  result valid from the unit (1-cycle latency).
- `red_result_i`  in  32  reduced word.
- `mem_wr_en_o`  out  1  RAM write strobe.
- `mem_wr_addr_o`  out  ADDR_W  write address.
- `mem_wr_data_o`  out  32  write data.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE → RUN on `start_i`: latch both bases; clear `rd_cnt` and `wr_cnt`.
- RUN: assert `mem_rd_en_o` every cycle with `mem_rd_addr_o = src_base + rd_cnt`, then increment `rd_cnt`. After issuing read `N_WORDS-1`, go to DRAIN.
- Operand stage: `red_valid_o` is the registered `mem_rd_en_o`. `red_src_o = mem_rd_data_i` passes through, unmodified.
- Writeback is combinational from the unit result:
  - `mem_wr_en_o = red_valid_i & (state==RUN|DRAIN)`.
  - `mem_wr_addr_o = dst_base + wr_cnt`.
  - `mem_wr_data_o = red_result_i`.
  - `wr_cnt` increments on each write.
- DRAIN → DONE when the write with `wr_cnt == N_WORDS-1` occurs. DONE lasts one cycle with `done_o = 1`, then returns to IDLE.
- Address arithmetic is modulo 2^ADDR_W, so base plus offset wraps silently.
- Counters are `$clog2(N_WORDS)+1` bits wide.
- In-place is safe: write k trails read k by 2 cycles, and reads advance monotonically.
- `abort_i` in RUN/DRAIN:
  - Next state is IDLE with no `done_o`.
  - Reads stop that cycle.
  - `red_flush_o` is held high for that cycle and the following 2 cycles.
  - `red_valid_o` is forced low during those cycles, and writes are suppressed.
- `abort_i` in IDLE/DONE is ignored.
- `start_i` outside IDLE is ignored, including in the DONE cycle.
- `start_i` together with `abort_i` in IDLE: start wins; abort applies only from RUN onward.
- `red_valid_i` outside RUN/DRAIN is ignored (no write).
- Reset (`rstn_i` low at a clock edge):
  - State goes to IDLE and counters to 0.
  - All outputs are 0 at the next edge, including `red_flush_o`.
  - Any in-flight words are dropped.

## Timing
- `start_i` is sampled at edge 0.
- Reads are issued in cycles 1..N_WORDS.
- `red_valid_o` is high in cycles 2..N_WORDS+1.
- Writes occur in cycles 3..N_WORDS+2.
- `done_o` is high in cycle N_WORDS+3. For N_WORDS=128, done is in cycle 131.
- Throughput is one word (two coefficients) per cycle, with no bubbles.
- Minimum start-to-start spacing is N_WORDS+4 cycles.
- `busy_o` is low in the DONE cycle.

## Structure
- Package `pqc_reduce_pkg` holds:
  - the state enum `red_state_t` (IDLE, RUN, DRAIN, DONE);
  - `RED_LAT = 1` (Barrett unit latency);
  - `RD_LAT = 1` (RAM read latency);
  - `FLUSH_CYC = 2`.
- Sub-module `reduce_addr_gen` contains the base register, counter and adder. It is instantiated twice, once for the read side and once for the write side.
- The FSM and the abort/flush counter live in the top level.

## Test plan
- **Full pass:** N_WORDS=128, base 0x00, RAM filled with 0x0D01_0001 → RAM words 0..127 all become 0x0000_0001. `done_o` is high in cycle 131 only.
- **Mixed values:** word k = {k+3329, k} for k < 128, dst 0x80 → word 0x80+k equals {k, k}. Source region is unchanged.
- **Wrap:** src 0xF0, dst 0xF8, ADDR_W=8, N_WORDS=16 → reads 0xF0..0xFF. Writes go to 0xF8..0xFF, then 0x00..0x07.
- **Abort:** `abort_i` in cycle 50 of a 128-word pass → `red_flush_o` is high in cycles 50–52, no writes from cycle 50 on, no `done_o`, `busy_o` low in cycle 51. A new start then completes normally.
- **Ignored requests:** `start_i` pulsed in cycles 10 and 131 of a pass → no restart. Exactly one `done_o` pulse.
- **Reset mid-pass:** `rstn_i` low in cycle 40 → all outputs 0 from the next edge. Counters are cleared, and a subsequent start behaves as in the full-pass scenario.
